// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port between NREQ requesters.
// A locked owner may keep the port for up to BURST_MAX consecutive reads; read data is registered.
module regfile_read_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*5-1:0] addr,
    output logic [NREQ-1:0]   gnt,
    output logic [4:0]        rf_sel,
    input  logic [WIDTH-1:0]  rf_data,
    output logic [WIDTH-1:0]  rd_data,
    output logic [NREQ-1:0]   rd_valid
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [BW-1:0]   burst_cnt, burst_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            keep;
    logic            found;
    int              idx;

    // gnt is one-hot, so any bit of gnt&req&lock means the owner asked to stay
    assign keep = (|(gnt & req & lock)) && (burst_cnt < BURST_LAST);

    always_comb begin
        gnt_nxt    = '0;
        rr_ptr_nxt = rr_ptr;
        burst_nxt  = '0;
        found      = 1'b0;
        idx        = 0;
        if (keep) begin
            gnt_nxt   = gnt;
            burst_nxt = burst_cnt + 1'b1;
        end else begin
            // rr_ptr already sits one past the last owner, so a released owner ends up last
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!found && req[idx]) begin
                    found        = 1'b1;
                    gnt_nxt[idx] = 1'b1;
                    rr_ptr_nxt   = PW'((idx + 1) % NREQ);
                end
            end
        end
    end

    always_comb begin
        rf_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            rf_sel = rf_sel | (addr[5*i +: 5] & {5{gnt[i]}});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            rd_data   <= '0;
            rd_valid  <= '0;
        end else begin
            gnt       <= gnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_nxt;
            rd_valid  <= gnt;
            if (|gnt) begin
                rd_data <= rf_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios plus random traffic, checked against
// a cycle-level owner/pointer model and a behavioural register file driving rf_data.
module tb_regfile_read_arbiter;

    localparam int WIDTH     = 32;
    localparam int NREQ      = 4;
    localparam int BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req, lock;
    logic [NREQ*5-1:0] addr;
    logic [NREQ-1:0]   gnt, rd_valid;
    logic [4:0]        rf_sel;
    logic [WIDTH-1:0]  rf_data, rd_data;
    logic [WIDTH-1:0]  regs [32];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: current owner, owner whose data is on rd_data, search start, burst length
    int               m_own  = -1;
    int               m_vld  = -1;
    int               m_ptr  = 0;
    int               m_cnt  = 0;
    logic [WIDTH-1:0] m_data = '0;

    regfile_read_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .addr(addr), .gnt(gnt),
        .rf_sel(rf_sel), .rf_data(rf_data), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;
    assign rf_data = regs[rf_sel];

    function automatic logic [NREQ-1:0] onehot(int o);
        logic [NREQ-1:0] r;
        r = '0;
        if (o >= 0) r[o] = 1'b1;
        return r;
    endfunction

    function automatic logic [4:0] exp_sel();
        if (m_own < 0) return 5'd0;
        return addr[5*m_own +: 5];
    endfunction

    task automatic model_reset();
        m_own = -1; m_vld = -1; m_ptr = 0; m_cnt = 0; m_data = '0;
    endtask

    task automatic tick();
        int nown;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (m_own >= 0) m_data = regs[addr[5*m_own +: 5]];
            m_vld = m_own;
            if (m_own >= 0 && req[m_own] && lock[m_own] && m_cnt < BURST_MAX - 1) begin
                m_cnt++;
            end else begin
                nown = -1;
                for (int k = 0; k < NREQ; k++)
                    if (nown < 0 && req[(m_ptr + k) % NREQ]) nown = (m_ptr + k) % NREQ;
                m_own = nown;
                if (nown >= 0) begin
                    m_ptr = (nown + 1) % NREQ;
                    m_cnt = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; lock = '0; addr = '0;
        tick(); tick();
        n_checks++;
        if (gnt !== '0 || rd_valid !== '0) begin
            n_fail++; $display("FAIL reset_ctl gnt=%b rd_valid=%b exp 0", gnt, rd_valid);
        end
        n_checks++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", rd_data); end
        n_checks++;
        if (rf_sel !== 5'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", rf_sel); end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        req = '0; lock = '0; addr = {NREQ{5'd7}};
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (gnt !== '0 || rd_valid !== '0 || rf_sel !== 5'd0) begin
                n_fail++; $display("FAIL idle gnt=%b rd_valid=%b rf_sel=%0d exp 0", gnt, rd_valid, rf_sel);
            end
        end
    endtask

    task automatic test_single_read();
        int n_g = 0;
        bit got = 0;
        regs[5] = 32'hDEAD_BEEF;
        addr[5*2 +: 5] = 5'd5;
        req = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (gnt !== onehot(m_own) || rd_valid !== onehot(m_vld)) begin
                n_fail++; $display("FAIL single gnt=%b rd_valid=%b exp %b %b", gnt, rd_valid, onehot(m_own), onehot(m_vld));
            end
            if (rd_valid == 4'b0100 && rd_data == 32'hDEAD_BEEF) got = 1;
            if (gnt[2]) begin
                n_g++;
                req[2] = 1'b0;
                #1;
                n_checks++;
                if (rf_sel !== 5'd5) begin n_fail++; $display("FAIL single_sel got %0d exp 5", rf_sel); end
            end
        end
        n_checks++;
        if (n_g != 1) begin n_fail++; $display("FAIL single_count grants=%0d exp 1", n_g); end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL single_data rd_valid 0100 with deadbeef seen=%0d exp 1", got); end
    endtask

    task automatic test_round_robin();
        int prev = -1;
        req = 4'b1111; lock = '0;
        for (int i = 0; i < NREQ; i++) addr[5*i +: 5] = 5'(10 + i);
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if (gnt !== onehot(m_own) || rd_valid !== onehot(m_vld)) begin
                n_fail++; $display("FAIL rr gnt=%b rd_valid=%b exp %b %b", gnt, rd_valid, onehot(m_own), onehot(m_vld));
            end
            if (m_vld >= 0) begin
                n_checks++;
                if (rd_data !== m_data) begin n_fail++; $display("FAIL rr_data got %h exp %h", rd_data, m_data); end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (gnt == onehot(i)) begin
                    if (prev >= 0) begin
                        n_checks++;
                        if (i != (prev + 1) % NREQ) begin n_fail++; $display("FAIL rr_order got %0d exp %0d", i, (prev + 1) % NREQ); end
                    end
                    prev = i;
                end
            end
        end
        req = '0;
        tick(); tick();
    endtask

    // with_other: req[3] competes from the first gnt[1]; otherwise req[3] joins at the 5th gnt[1]
    task automatic test_burst(input bit with_other);
        int nb = 0, nv = 0, exp_nb;
        bit seen3 = 0;
        exp_nb = with_other ? BURST_MAX : 2 * BURST_MAX;
        for (int r = 1; r <= 2 * BURST_MAX; r++) regs[r] = $urandom;
        addr[5*1 +: 5] = 5'd1;
        req = 4'b0010; lock = 4'b0010;
        for (int c = 0; c < 16 && !seen3; c++) begin
            tick();
            n_checks++;
            if (gnt !== onehot(m_own) || rd_valid !== onehot(m_vld)) begin
                n_fail++; $display("FAIL burst gnt=%b rd_valid=%b exp %b %b", gnt, rd_valid, onehot(m_own), onehot(m_vld));
            end
            if (rd_valid[1]) begin
                nv++;
                n_checks++;
                if (rd_data !== regs[nv]) begin n_fail++; $display("FAIL burst_data read %0d got %h exp %h", nv, rd_data, regs[nv]); end
            end
            if (gnt[3]) begin
                seen3 = 1;
                n_checks++;
                if (nb != exp_nb) begin n_fail++; $display("FAIL burst_len got %0d exp %0d", nb, exp_nb); end
                req = '0; lock = '0;
            end
            if (gnt[1]) begin
                nb++;
                addr[5*1 +: 5] = 5'(nb);
                if (with_other || nb == BURST_MAX + 1) req[3] = 1'b1;
            end
            #1;
            n_checks++;
            if (rf_sel !== exp_sel()) begin n_fail++; $display("FAIL burst_sel got %0d exp %0d", rf_sel, exp_sel()); end
        end
        n_checks++;
        if (!seen3) begin n_fail++; $display("FAIL burst_timeout gnt3_seen=%0d exp 1", seen3); end
        req = '0; lock = '0;
        tick(); tick();
    endtask

    task automatic test_wrap();
        bit ok3 = 0, ok0 = 0;
        req = 4'b1000; addr = {5'd3, 5'd0, 5'd0, 5'd9};
        for (int c = 0; c < 8 && !ok0; c++) begin
            tick();
            n_checks++;
            if (gnt !== onehot(m_own)) begin n_fail++; $display("FAIL wrap gnt=%b exp %b", gnt, onehot(m_own)); end
            if (gnt[0]) begin ok0 = ok3; req[0] = 1'b0; end
            if (gnt[3]) begin ok3 = 1; req = 4'b0001; end
            #1;
            n_checks++;
            if (rf_sel !== exp_sel()) begin n_fail++; $display("FAIL wrap_sel got %0d exp %0d", rf_sel, exp_sel()); end
        end
        n_checks++;
        if (!ok0) begin n_fail++; $display("FAIL wrap_order gnt3_then_gnt0=%0d exp 1", ok0); end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick();
            n_checks++;
            if (gnt !== onehot(m_own) || rd_valid !== onehot(m_vld)) begin
                n_fail++; $display("FAIL rand cyc %0d gnt=%b rd_valid=%b exp %b %b", c, gnt, rd_valid, onehot(m_own), onehot(m_vld));
            end
            if (m_vld >= 0) begin
                n_checks++;
                if (rd_data !== m_data) begin n_fail++; $display("FAIL rand_data cyc %0d got %h exp %h", c, rd_data, m_data); end
            end
            req  = NREQ'($urandom);
            lock = NREQ'($urandom);
            addr = (NREQ*5)'({$urandom, $urandom});
            if ($urandom_range(3) == 0) regs[$urandom_range(31)] = $urandom;
            #1;
            n_checks++;
            if (rf_sel !== exp_sel()) begin n_fail++; $display("FAIL rand_sel cyc %0d got %0d exp %0d", c, rf_sel, exp_sel()); end
        end
        req = '0; lock = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_burst();
        int c = 0;
        addr[5*1 +: 5] = 5'd2;
        req = 4'b0010; lock = 4'b0010;
        do begin tick(); c++; end while (!gnt[1] && c < 8);
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (gnt !== '0 || rd_valid !== '0 || rd_data !== '0) begin
            n_fail++; $display("FAIL reset_mid gnt=%b rd_valid=%b rd_data=%h exp 0", gnt, rd_valid, rd_data);
        end
        model_reset();
        tick();
        reset = 1'b0;
        req = 4'b1111; lock = '0;
        n_checks++;
        if (rd_valid !== '0) begin n_fail++; $display("FAIL reset_drop rd_valid=%b exp 0", rd_valid); end
        tick();
        n_checks++;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_ptr gnt=%b exp 0001", gnt); end
        tick();
        n_checks++;
        if (gnt !== 4'b0010 || rd_valid !== 4'b0001) begin
            n_fail++; $display("FAIL reset_next gnt=%b rd_valid=%b exp 0010 0001", gnt, rd_valid);
        end
        req = '0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        test_reset();
        test_idle();
        test_single_read();
        test_round_robin();
        test_burst(1'b1);
        test_burst(1'b0);
        test_wrap();
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
